// File: rtl/add_sub_seq.sv
// Multi-cycle adder/subtractor: SLICE bits per clock, carry held in a register between slices.
// Valid/ready on both sides; result and flags are held from the final slice until accepted.
module add_sub_seq #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             add_sub_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             borrow,
    output logic             overflow,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    generate
        if (SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_cfg_err
            $error("add_sub_seq: WIDTH must be a non-zero multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic              cry_q;
    logic              sel_q;
    logic [WIDTH-1:0]  a_q, b_q;
    logic              accept;
    logic [SLICE:0]    slice_res;
    logic [WIDTH-1:0]  sum_nx;
    int                idx;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (cnt_q == LAST) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // b_q already holds ~B when subtracting, so one adder serves both modes.
    always_comb begin
        idx       = int'(cnt_q) * SLICE;
        slice_res = {1'b0, a_q[idx +: SLICE]} + {1'b0, b_q[idx +: SLICE]} + (SLICE+1)'(cry_q);
        sum_nx    = sum;
        sum_nx[idx +: SLICE] = slice_res[SLICE-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cry_q    <= 1'b0;
            sel_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sum      <= '0;
            carry    <= 1'b0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q   <= a;
                b_q   <= b ^ {WIDTH{add_sub_sel}};
                sel_q <= add_sub_sel;
                cry_q <= add_sub_sel;
                cnt_q <= '0;
            end
            if (state_q == CALC) begin
                sum   <= sum_nx;
                cry_q <= slice_res[SLICE];
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    carry    <= slice_res[SLICE] & ~sel_q;
                    borrow   <= ~slice_res[SLICE] & sel_q;
                    overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_nx[WIDTH-1] != a_q[WIDTH-1]);
                    zero     <= ~|sum_nx;
                end
            end
        end
    end

endmodule

// File: tb/tb_add_sub_seq.sv
// Bench for add_sub_seq: four configurations side by side, directed vectors,
// handshake/reset corner cases and randomized ops against an arithmetic reference model.
module tb_add_sub_seq;

    localparam int ND = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [ND-1:0] in_valid, in_ready, out_valid, out_ready, sel;
    logic [ND-1:0] carry, borrow, overflow, zero;
    logic [31:0]   a_d [ND];
    logic [31:0]   b_d [ND];
    logic [15:0]   sum0, sum1, sum2;
    logic [31:0]   sum3;

    int n_cmp = 0;
    int n_bad = 0;

    add_sub_seq #(.WIDTH(16), .SLICE(4)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a_d[0][15:0]), .b(b_d[0][15:0]), .add_sub_sel(sel[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .sum(sum0),
        .carry(carry[0]), .borrow(borrow[0]), .overflow(overflow[0]), .zero(zero[0]));

    add_sub_seq #(.WIDTH(16), .SLICE(16)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a_d[1][15:0]), .b(b_d[1][15:0]), .add_sub_sel(sel[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .sum(sum1),
        .carry(carry[1]), .borrow(borrow[1]), .overflow(overflow[1]), .zero(zero[1]));

    add_sub_seq #(.WIDTH(16), .SLICE(1)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a_d[2][15:0]), .b(b_d[2][15:0]), .add_sub_sel(sel[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .sum(sum2),
        .carry(carry[2]), .borrow(borrow[2]), .overflow(overflow[2]), .zero(zero[2]));

    add_sub_seq #(.WIDTH(32), .SLICE(8)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .a(a_d[3]), .b(b_d[3]), .add_sub_sel(sel[3]),
        .out_valid(out_valid[3]), .out_ready(out_ready[3]), .sum(sum3),
        .carry(carry[3]), .borrow(borrow[3]), .overflow(overflow[3]), .zero(zero[3]));

    function automatic int width_of(input int k);
        return (k == 3) ? 32 : 16;
    endfunction

    function automatic int nslice_of(input int k);
        case (k)
            0: return 4;
            1: return 1;
            2: return 16;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] get_sum(input int k);
        case (k)
            0: return {16'd0, sum0};
            1: return {16'd0, sum1};
            2: return {16'd0, sum2};
            default: return sum3;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values, signed range test for overflow.
    task automatic ref_model(input int w, input logic [31:0] av, input logic [31:0] bv, input logic s,
                             output logic [31:0] rs, output logic rc, output logic rb,
                             output logic ro, output logic rz);
        longint unsigned mask, ua, ub, r;
        longint sa, sb, sr, smax, smin;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, av} & mask;
        ub   = {32'd0, bv} & mask;
        sa   = ((ua >> (w-1)) & 64'd1) != 0 ? longint'(ua) - (longint'(1) << w) : longint'(ua);
        sb   = ((ub >> (w-1)) & 64'd1) != 0 ? longint'(ub) - (longint'(1) << w) : longint'(ub);
        smax = (longint'(1) << (w-1)) - 1;
        smin = -(longint'(1) << (w-1));
        if (!s) begin
            r  = ua + ub;
            rc = ((r >> w) & 64'd1) != 0;
            rb = 1'b0;
            sr = sa + sb;
        end else begin
            r  = ua - ub;
            rc = 1'b0;
            rb = ua < ub;
            sr = sa - sb;
        end
        r  = r & mask;
        rs = r[31:0];
        ro = (sr > smax) || (sr < smin);
        rz = (r == 0);
    endtask

    task automatic do_op(input int k, input logic [31:0] av, input logic [31:0] bv, input logic s,
                         input int hold, input bit scramble,
                         output logic [31:0] rs, output logic rc, output logic rb,
                         output logic ro, output logic rz);
        int lat;
        bit done;
        @(negedge clk);
        chk($sformatf("d%0d_ready_idle", k), {31'd0, in_ready[k]}, 32'd1);
        a_d[k] = av; b_d[k] = bv; sel[k] = s; in_valid[k] = 1'b1;
        @(posedge clk);
        lat = 0; done = 1'b0;
        while (!done && lat < 64) begin
            @(negedge clk);
            if (scramble) begin
                in_valid[k] = 1'b1; a_d[k] = $urandom; b_d[k] = $urandom; sel[k] = 1'($urandom_range(0, 1));
            end else begin
                in_valid[k] = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            if (out_valid[k]) done = 1'b1;
        end
        in_valid[k] = 1'b0;
        chk($sformatf("d%0d_latency", k), lat, nslice_of(k));
        rs = get_sum(k); rc = carry[k]; rb = borrow[k]; ro = overflow[k]; rz = zero[k];
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk($sformatf("d%0d_hold_valid", k), {31'd0, out_valid[k]}, 32'd1);
            chk($sformatf("d%0d_hold_sum", k), get_sum(k), rs);
            chk($sformatf("d%0d_hold_ready", k), {31'd0, in_ready[k]}, 32'd0);
        end
        @(negedge clk);
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        chk($sformatf("d%0d_release_valid", k), {31'd0, out_valid[k]}, 32'd0);
        chk($sformatf("d%0d_release_ready", k), {31'd0, in_ready[k]}, 32'd1);
    endtask

    function automatic logic [31:0] pick(input int w);
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'd1 << (w-1);
            3: v = (32'd1 << (w-1)) - 32'd1;
            default: v = $urandom;
        endcase
        if (w < 32) v = v & ((32'd1 << w) - 32'd1);
        return v;
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] es;
        logic        ec, eb, eo, ez;
    } vec_t;

    vec_t tv [6];

    initial begin
        logic [31:0] rs, es, av, bv;
        logic rc, rb, ro, rz, ec, eb, eo, ez, s;
        int cnt;

        tv[0] = '{32'h7FFF, 32'h0001, 1'b0, 32'h8000, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[1] = '{32'hFFFF, 32'h0001, 1'b0, 32'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
        tv[2] = '{32'h0003, 32'h0005, 1'b1, 32'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[3] = '{32'h8000, 32'h0001, 1'b1, 32'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[4] = '{32'h0000, 32'h0000, 1'b1, 32'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
        tv[5] = '{32'h1234, 32'h1111, 1'b0, 32'h2345, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        in_valid = '0; out_ready = '0; sel = '0;
        for (int k = 0; k < ND; k++) begin a_d[k] = '0; b_d[k] = '0; end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, in_ready[0]}, 32'd1);
        chk("rst_valid", {31'd0, out_valid[0]}, 32'd0);
        chk("rst_sum", get_sum(0), 32'd0);
        chk("rst_flags", {28'd0, carry[0], borrow[0], overflow[0], zero[0]}, 32'd0);
        chk("rst_ready_all", {28'd0, in_ready}, 32'hF);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors; the 0x8000-0x0001 case holds out_ready low for five cycles.
        for (int i = 0; i < 6; i++) begin
            do_op(0, tv[i].a, tv[i].b, tv[i].s, (i == 3) ? 5 : 0, 1'b0, rs, rc, rb, ro, rz);
            chk($sformatf("vec%0d_sum", i), rs, tv[i].es);
            chk($sformatf("vec%0d_flags", i), {28'd0, rc, rb, ro, rz},
                {28'd0, tv[i].ec, tv[i].eb, tv[i].eo, tv[i].ez});
        end

        // New operands presented while busy must not disturb the accepted operation.
        do_op(0, 32'h1111, 32'h2222, 1'b0, 0, 1'b1, rs, rc, rb, ro, rz);
        chk("scramble_sum", rs, 32'h3333);
        chk("scramble_flags", {28'd0, rc, rb, ro, rz}, 32'd0);

        // Abort in the second compute cycle.
        @(negedge clk);
        a_d[0] = 32'hFFFF; b_d[0] = 32'hFFFF; sel[0] = 1'b0; in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_ready", {31'd0, in_ready[0]}, 32'd1);
        chk("abort_valid", {31'd0, out_valid[0]}, 32'd0);
        chk("abort_sum", get_sum(0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid[0]) cnt++;
        end
        chk("abort_no_valid", cnt, 0);

        // Reset wins over a simultaneous in_valid.
        @(negedge clk);
        rst = 1'b1; in_valid[0] = 1'b1; a_d[0] = 32'h0001; b_d[0] = 32'h0001;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid[0] = 1'b0;
        @(posedge clk); #1;
        chk("rst_wins_ready", {31'd0, in_ready[0]}, 32'd1);
        cnt = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid[0]) cnt++;
        end
        chk("rst_wins_no_valid", cnt, 0);

        do_op(0, 32'h1234, 32'h1111, 1'b0, 0, 1'b0, rs, rc, rb, ro, rz);
        chk("post_abort_sum", rs, 32'h2345);

        // Randomized ops on every configuration.
        for (int k = 0; k < ND; k++) begin
            for (int n = 0; n < ((k == 0) ? 300 : 1000); n++) begin
                av = pick(width_of(k));
                bv = pick(width_of(k));
                s  = 1'($urandom_range(0, 1));
                ref_model(width_of(k), av, bv, s, es, ec, eb, eo, ez);
                do_op(k, av, bv, s, 0, n[0], rs, rc, rb, ro, rz);
                chk($sformatf("d%0d_rnd%0d_sum", k, n), rs, es);
                chk($sformatf("d%0d_rnd%0d_flags", k, n), {28'd0, rc, rb, ro, rz},
                    {28'd0, ec, eb, eo, ez});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/add_sub_seq.md
Name: add_sub_seq

Overview:
- Parametrised, multi-cycle adder/subtractor. Successor to the fixed 16-bit ripple add/sub used by the MIPS-16 ALU.
- Processes SLICE bits per clock and carries between slices in a register, so WIDTH is not bound by a single-cycle ripple path.
- Uses a valid/ready handshake on both sides and adds borrow, signed-overflow and zero flags.
- Sits between the ALU operand muxes and the writeback/flag registers.

Parameters:
- WIDTH, 16, operand and result width in bits; must be an integer multiple of SLICE.
- SLICE, 4, bits computed per clock; 1 <= SLICE <= WIDTH.
- NSLICE (local), WIDTH/SLICE, number of compute cycles.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset.
- in_valid  in  1  operands and mode are valid this cycle.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- add_sub_sel  in  1  0 = A+B, 1 = A-B.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- carry  out  1  carry-out of A+B; forced 0 when subtracting (existing ALU convention).
- borrow  out  1  1 when subtracting and A<B unsigned; forced 0 when adding.
- overflow  out  1  two's-complement signed overflow for the selected operation.
- zero  out  1  sum == 0.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state: state IDLE, slice counter 0, carry register 0, sum 0, all flags 0, out_valid 0, in_ready 1.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, add_sub_sel, and b XOR {WIDTH{add_sub_sel}}.
  - Set carry register = add_sub_sel; counter = 0; go to CALC.
- CALC:
  - in_ready=0, out_valid=0.
  - Each edge: slice i = counter computes {c, s} = A[i] + B'[i] + carry_reg over SLICE bits.
  - s is written into sum[i*SLICE +: SLICE]; carry_reg <= c; counter++.
  - The edge that computes slice NSLICE-1 also computes the flags and moves to DONE.
- Latency: out_valid rises exactly NSLICE edges after the accepting edge (4 at defaults; 1 when SLICE==WIDTH).
- Flag rules, evaluated at the final slice:
  - Raw carry-out cf = final c.
  - carry = cf & ~add_sub_sel.
  - borrow = ~cf & add_sub_sel.
  - overflow = carry into MSB XOR carry out of MSB; equivalently (A[W-1]==B'[W-1]) && (sum[W-1]!=A[W-1]).
  - zero = ~|sum.
- DONE:
  - out_valid=1; sum and flags held stable until accepted.
  - On out_ready: next state IDLE, out_valid=0.
  - sum and flags keep their last values in IDLE and CALC until overwritten; only out_valid qualifies them.
- No overlap: a new operation is accepted only in IDLE, so at most one operation is in flight. in_valid while busy is ignored and must be held by the producer.
- out_ready while out_valid=0 has no effect.
- Operand changes on a/b/add_sub_sel after acceptance do not affect the in-flight result.
- Reset mid-operation (CALC or DONE): abandon the operation, return to the reset state next edge, emit no out_valid for it.
- Reset and in_valid together: reset wins; no operation is accepted.
- Elaboration: WIDTH%SLICE != 0 is a configuration error and must be flagged at elaboration.

Test Plan:
- Defaults. Send a=0x7FFF, b=0x0001, add → after 4 cycles out_valid=1, sum=0x8000, carry=0, overflow=1, zero=0, borrow=0.
- Send a=0xFFFF, b=0x0001, add → sum=0x0000, carry=1, zero=1, overflow=0. Then a=0x0003, b=0x0005, sub → sum=0xFFFE, borrow=1, carry=0, overflow=0.
- Send a=0x8000, b=0x0001, sub → sum=0x7FFF, overflow=1, borrow=0. Hold out_ready=0 for 5 cycles → out_valid and sum stay stable, in_ready=0 throughout; in_ready=1 the cycle after out_ready pulses.
- Pulse rst during the 2nd CALC cycle → next cycle in_ready=1, out_valid=0, sum=0; out_valid never asserts for the aborted operation. Then a new op 0x1234+0x1111 completes with sum=0x2345.
- Parameter sweep: (WIDTH, SLICE) = (16,16), (16,1), (32,8). Run 1000 random add/sub ops each against a reference model. Latency must be 1, 16 and 4 cycles respectively, and all flags must match.
- Toggle in_valid with new operands while in CALC → ignored; the result matches the originally accepted operands.
